// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared constants for the msrv32 writeback stage.
//   WB_SEL_*  writeback source select codes
//   LS_*      load size codes
//   FAULT_*   load fault cause codes
//   wb_state_t writeback stage FSM states
package msrv32_pkg;

  localparam logic [2:0] WB_SEL_ALU    = 3'd0;
  localparam logic [2:0] WB_SEL_LOAD   = 3'd1;
  localparam logic [2:0] WB_SEL_SRC    = 3'd2;
  localparam logic [2:0] WB_SEL_IADDER = 3'd3;
  localparam logic [2:0] WB_SEL_CSR    = 3'd4;
  localparam logic [2:0] WB_SEL_PC4    = 3'd5;

  localparam logic [1:0] LS_BYTE   = 2'd0;
  localparam logic [1:0] LS_HALF   = 2'd1;
  localparam logic [1:0] LS_WORD   = 2'd2;
  localparam logic [1:0] LS_DOUBLE = 2'd3;

  localparam logic [1:0] FAULT_BUS      = 2'd0;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'd1;
  localparam logic [1:0] FAULT_MISALIGN = 2'd2;
  localparam logic [1:0] FAULT_SIZE     = 2'd3;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } wb_state_t;

endpackage

// File: rtl/msrv32_load_align.sv
// msrv32_load_align: combinational load data alignment and extension.
//   i_data         raw bus read data
//   i_offset       byte offset of the access within the bus word
//   i_size         LS_* access size
//   i_unsigned     zero-extend instead of sign-extend
//   o_result_c     shifted and extended load value
//   o_misaligned_c offset is not a multiple of the access size
module msrv32_load_align
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  i_data,
  input  logic [OFF_W-1:0] i_offset,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  output logic [XLEN-1:0]  o_result_c,
  output logic             o_misaligned_c
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_mask;
  logic            w_sign;

  assign w_shifted = i_data >> {i_offset, 3'b000};

  // Mask of the bits that belong to the access, plus its sign bit.
  always_comb begin
    w_mask         = '1;
    w_sign         = w_shifted[XLEN-1];
    o_misaligned_c = 1'b0;
    case (i_size)
      LS_BYTE: begin
        w_mask = XLEN'(8'hFF);
        w_sign = w_shifted[7];
      end
      LS_HALF: begin
        w_mask         = XLEN'(16'hFFFF);
        w_sign         = w_shifted[15];
        o_misaligned_c = i_offset[0];
      end
      LS_WORD: begin
        w_mask         = XLEN'(32'hFFFF_FFFF);
        w_sign         = w_shifted[31];
        o_misaligned_c = |i_offset[1:0];
      end
      default: o_misaligned_c = |i_offset;
    endcase
  end

  // Bits above the access are filled with the sign (or zero).
  assign o_result_c = (w_shifted & w_mask) | ({XLEN{w_sign & ~i_unsigned}} & ~w_mask);

endmodule

// File: rtl/msrv32_wb_stage.sv
// msrv32_wb_stage: registered writeback stage of the msrv32 pipeline.
//   s2_valid_in/s2_ready_out   operation handshake from stage 2
//   flush_in                   kill current / in-flight operation
//   wb_sel_in, rd_*, is_load_in, load_*  operation context
//   alu_result_in .. pc_plus_4_in         writeback candidates
//   ms_riscv32_mp_data_*/dmdata_in        wait-stated data bus response
//   wb_*_out                   one registered writeback per operation
//   load_fault_out/fault_cause_out        one-cycle load fault pulse
module msrv32_wb_stage
  import msrv32_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            s2_valid_in,
  output logic            s2_ready_out,
  input  logic            flush_in,
  input  logic [2:0]      wb_sel_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            rd_wr_en_in,
  input  logic            is_load_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] alu_src_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic [XLEN-1:0] csr_data_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic [XLEN-1:0] ms_riscv32_mp_dmdata_in,
  input  logic            ms_riscv32_mp_data_hready_in,
  input  logic            ms_riscv32_mp_data_hresp_in,
  output logic            wb_valid_out,
  output logic [4:0]      wb_rd_addr_out,
  output logic            wb_wr_en_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic            load_fault_out,
  output logic [1:0]      fault_cause_out
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);
  localparam int unsigned CNT_W = 8;

  wb_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_kill, w_kill_nxt;

  logic [OFF_W-1:0] r_offset;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [4:0]       r_rd_addr;
  logic             r_rd_wr_en;

  logic             w_accept;
  logic             w_latch;
  logic             w_kill_eff;
  logic             w_size_illegal;
  logic             w_misaligned;
  logic [OFF_W-1:0] w_al_offset;
  logic [1:0]       w_al_size;
  logic             w_al_unsigned;
  logic [XLEN-1:0]  w_load_data;
  logic [XLEN-1:0]  w_mux;

  logic             w_wb_valid_nxt;
  logic             w_wb_wr_en_nxt;
  logic [4:0]       w_wb_rd_addr_nxt;
  logic [XLEN-1:0]  w_wb_data_nxt;
  logic             w_fault_nxt;
  logic [1:0]       w_cause_nxt;

  assign w_accept       = s2_valid_in & s2_ready_out & ~flush_in;
  assign w_kill_eff     = r_kill | flush_in;
  assign w_size_illegal = (load_size_in == LS_DOUBLE) && (XLEN == 32);

  // Aligner sees the live request in RUN and the latched context while waiting.
  assign w_al_offset   = (r_state == S_WAIT) ? r_offset   : iadder_in[OFF_W-1:0];
  assign w_al_size     = (r_state == S_WAIT) ? r_size     : load_size_in;
  assign w_al_unsigned = (r_state == S_WAIT) ? r_unsigned : load_unsigned_in;

  msrv32_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_data         (ms_riscv32_mp_dmdata_in),
    .i_offset       (w_al_offset),
    .i_size         (w_al_size),
    .i_unsigned     (w_al_unsigned),
    .o_result_c     (w_load_data),
    .o_misaligned_c (w_misaligned)
  );

  // Writeback source mux for non-load operations.
  always_comb begin
    w_mux = '0;
    case (wb_sel_in)
      WB_SEL_ALU:    w_mux = alu_result_in;
      WB_SEL_LOAD:   w_mux = w_load_data;
      WB_SEL_SRC:    w_mux = alu_src_in;
      WB_SEL_IADDER: w_mux = iadder_in;
      WB_SEL_CSR:    w_mux = csr_data_in;
      WB_SEL_PC4:    w_mux = pc_plus_4_in;
      default:       w_mux = '0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_kill_nxt       = r_kill;
    w_latch          = 1'b0;
    w_wb_valid_nxt   = 1'b0;
    w_wb_wr_en_nxt   = 1'b0;
    w_wb_rd_addr_nxt = wb_rd_addr_out;
    w_wb_data_nxt    = wb_data_out;
    w_fault_nxt      = 1'b0;
    w_cause_nxt      = fault_cause_out;
    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          if (!is_load_in) begin
            w_wb_valid_nxt   = 1'b1;
            w_wb_wr_en_nxt   = rd_wr_en_in;
            w_wb_rd_addr_nxt = rd_addr_in;
            w_wb_data_nxt    = w_mux;
          end else if (w_misaligned) begin
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
            w_cause_nxt = FAULT_MISALIGN;
          end else if (w_size_illegal) begin
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
            w_cause_nxt = FAULT_SIZE;
          end else begin
            w_latch     = 1'b1;
            w_cnt_nxt   = '0;
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_in) begin
          w_kill_nxt = 1'b1;
        end
        if (ms_riscv32_mp_data_hready_in) begin
          w_state_nxt = S_RUN;
          if (w_kill_eff) begin
            w_state_nxt = S_RUN;
          end else if (ms_riscv32_mp_data_hresp_in) begin
            w_state_nxt = S_FAULT;
            w_fault_nxt = 1'b1;
            w_cause_nxt = FAULT_BUS;
          end else begin
            w_wb_valid_nxt   = 1'b1;
            w_wb_wr_en_nxt   = r_rd_wr_en;
            w_wb_rd_addr_nxt = r_rd_addr;
            w_wb_data_nxt    = w_load_data;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          // Deciding cycle is the MEM_TIMEOUT-th consecutive stalled cycle.
          if (r_cnt + CNT_W'(1) == CNT_W'(MEM_TIMEOUT)) begin
            w_state_nxt = S_RUN;
            if (!w_kill_eff) begin
              w_state_nxt = S_FAULT;
              w_fault_nxt = 1'b1;
              w_cause_nxt = FAULT_TIMEOUT;
            end
          end
        end
        if (w_state_nxt != S_WAIT) begin
          w_kill_nxt = 1'b0;
          w_cnt_nxt  = '0;
        end
      end
      S_FAULT: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State, counter, kill flag and output registers.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state         <= S_RUN;
      r_cnt           <= '0;
      r_kill          <= 1'b0;
      s2_ready_out    <= 1'b1;
      wb_valid_out    <= 1'b0;
      wb_wr_en_out    <= 1'b0;
      wb_rd_addr_out  <= '0;
      wb_data_out     <= '0;
      load_fault_out  <= 1'b0;
      fault_cause_out <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_kill          <= w_kill_nxt;
      s2_ready_out    <= (w_state_nxt == S_RUN);
      wb_valid_out    <= w_wb_valid_nxt;
      wb_wr_en_out    <= w_wb_wr_en_nxt;
      wb_rd_addr_out  <= w_wb_rd_addr_nxt;
      wb_data_out     <= w_wb_data_nxt;
      load_fault_out  <= w_fault_nxt;
      fault_cause_out <= w_cause_nxt;
    end
  end

  // Load context captured at accept.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_offset   <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_wr_en <= 1'b0;
    end else if (w_latch) begin
      r_offset   <= iadder_in[OFF_W-1:0];
      r_size     <= load_size_in;
      r_unsigned <= load_unsigned_in;
      r_rd_addr  <= rd_addr_in;
      r_rd_wr_en <= rd_wr_en_in;
    end
  end

endmodule

// File: tb/tb_msrv32_wb_stage.sv
module tb_msrv32_wb_stage;

  localparam int TMO     = 4;
  localparam int K_WB    = 0;
  localparam int K_FAULT = 1;
  localparam int K_NONE  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, flush, isld, wen, uns, hready, hresp;
  logic [2:0]  sel;
  logic [4:0]  rd;
  logic [1:0]  size;
  logic [63:0] alu, src, iadd, csr, pc4, dm;

  logic        rdy32, v32, we32, f32;
  logic [4:0]  rd32;
  logic [31:0] d32;
  logic [1:0]  c32;
  logic        rdy64, v64, we64, f64;
  logic [4:0]  rd64;
  logic [63:0] d64;
  logic [1:0]  c64;

  logic        g64;
  logic        m_rdy, m_v, m_we, m_f;
  logic [4:0]  m_rd;
  logic [63:0] m_d;
  logic [1:0]  m_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  msrv32_wb_stage #(.XLEN(32), .MEM_TIMEOUT(TMO)) u_dut32 (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .s2_valid_in                  (valid),
    .s2_ready_out                 (rdy32),
    .flush_in                     (flush),
    .wb_sel_in                    (sel),
    .rd_addr_in                   (rd),
    .rd_wr_en_in                  (wen),
    .is_load_in                   (isld),
    .load_size_in                 (size),
    .load_unsigned_in             (uns),
    .alu_result_in                (alu[31:0]),
    .alu_src_in                   (src[31:0]),
    .iadder_in                    (iadd[31:0]),
    .csr_data_in                  (csr[31:0]),
    .pc_plus_4_in                 (pc4[31:0]),
    .ms_riscv32_mp_dmdata_in      (dm[31:0]),
    .ms_riscv32_mp_data_hready_in (hready),
    .ms_riscv32_mp_data_hresp_in  (hresp),
    .wb_valid_out                 (v32),
    .wb_rd_addr_out               (rd32),
    .wb_wr_en_out                 (we32),
    .wb_data_out                  (d32),
    .load_fault_out               (f32),
    .fault_cause_out              (c32)
  );

  msrv32_wb_stage #(.XLEN(64), .MEM_TIMEOUT(TMO)) u_dut64 (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .s2_valid_in                  (valid),
    .s2_ready_out                 (rdy64),
    .flush_in                     (flush),
    .wb_sel_in                    (sel),
    .rd_addr_in                   (rd),
    .rd_wr_en_in                  (wen),
    .is_load_in                   (isld),
    .load_size_in                 (size),
    .load_unsigned_in             (uns),
    .alu_result_in                (alu),
    .alu_src_in                   (src),
    .iadder_in                    (iadd),
    .csr_data_in                  (csr),
    .pc_plus_4_in                 (pc4),
    .ms_riscv32_mp_dmdata_in      (dm),
    .ms_riscv32_mp_data_hready_in (hready),
    .ms_riscv32_mp_data_hresp_in  (hresp),
    .wb_valid_out                 (v64),
    .wb_rd_addr_out               (rd64),
    .wb_wr_en_out                 (we64),
    .wb_data_out                  (d64),
    .load_fault_out               (f64),
    .fault_cause_out              (c64)
  );

  assign m_rdy = g64 ? rdy64 : rdy32;
  assign m_v   = g64 ? v64   : v32;
  assign m_we  = g64 ? we64  : we32;
  assign m_f   = g64 ? f64   : f32;
  assign m_rd  = g64 ? rd64  : rd32;
  assign m_d   = g64 ? d64   : {32'd0, d32};
  assign m_c   = g64 ? c64   : c32;

  typedef struct {
    logic [2:0]  sel;
    logic [63:0] alu;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference load value: shift by offset bytes, keep the accessed bits, extend.
  function automatic logic [63:0] ref_load(input int xl, input logic [63:0] d, input int off,
                                           input logic [1:0] sz, input logic u);
    logic [63:0] v, mask;
    int bits;
    if (xl == 32) d = d & 64'hFFFF_FFFF;
    bits = 8 << sz;
    v = d >> (8 * off);
    if (bits < 64) begin
      mask = (64'd1 << bits) - 64'd1;
      v = v & mask;
      if (!u && v[bits-1]) v = v | ~mask;
    end
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_mux(input logic [2:0] s, input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [63:0] d, input logic [63:0] e);
    case (s)
      3'd0: return a;
      3'd2: return b;
      3'd3: return c;
      3'd4: return d;
      3'd5: return e;
      default: return 64'd0;
    endcase
  endfunction

  // Outcome of one load transaction from the stage's rules.
  task automatic predict(input int xl, input logic [1:0] sz, input int off, input logic u,
                         input logic [63:0] d, input int waits, input logic err, input int fl,
                         output int kind, output logic [1:0] cause, output logic [63:0] val);
    int nbytes, last;
    nbytes = 1 << sz;
    kind = K_WB; cause = 2'd0; val = 64'd0;
    last = (waits < TMO) ? waits : TMO - 1;
    if (off % nbytes != 0) begin kind = K_FAULT; cause = 2'd2; end
    else if (nbytes > xl / 8) begin kind = K_FAULT; cause = 2'd3; end
    else if (fl >= 0 && fl <= last) kind = K_NONE;
    else if (waits >= TMO) begin kind = K_FAULT; cause = 2'd1; end
    else if (err) begin kind = K_FAULT; cause = 2'd0; end
    else val = ref_load(xl, d, off, sz, u);
  endtask

  task automatic drain();
    hready = 1'b1; hresp = 1'b0; flush = 1'b0; valid = 1'b0;
    step(); step();
    hready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] s, input logic [4:0] r, input logic w, input logic [63:0] exp);
    chk("op_ready", 64'(m_rdy), 64'd1);
    valid = 1'b1; isld = 1'b0; flush = 1'b0; sel = s; rd = r; wen = w;
    step();
    valid = 1'b0; rd = 5'($urandom);
    chk("op_valid", 64'(m_v), 64'd1);
    chk("op_data", m_d, exp);
    chk("op_rd", 64'(m_rd), 64'(r));
    chk("op_wen", 64'(m_we), 64'(w));
    chk("op_fault", 64'(m_f), 64'd0);
  endtask

  task automatic run_load(input logic [1:0] sz, input int off, input logic u, input logic [63:0] d,
                          input int waits, input logic err, input int fl, input logic [4:0] r,
                          input logic w, input int kind, input logic [1:0] cause, input logic [63:0] val);
    bit done;
    chk("ld_ready_accept", 64'(m_rdy), 64'd1);
    valid = 1'b1; isld = 1'b1; flush = 1'b0; size = sz; uns = u; rd = r; wen = w;
    sel = 3'($urandom);
    iadd = ({$urandom(), $urandom()} & ~64'h7) | 64'(off);
    hready = 1'b0; hresp = 1'b0;
    step();
    valid = 1'b0; rd = 5'($urandom); wen = ~w; size = 2'($urandom); iadd = {$urandom(), $urandom()};
    if (kind == K_FAULT && cause >= 2'd2) begin
      chk("ld_imm_fault", 64'(m_f), 64'd1);
      chk("ld_imm_cause", 64'(m_c), 64'(cause));
      chk("ld_imm_nowb", 64'(m_v), 64'd0);
      chk("ld_imm_ready", 64'(m_rdy), 64'd0);
      step();
      chk("ld_imm_ready_after", 64'(m_rdy), 64'd1);
      chk("ld_imm_fault_once", 64'(m_f), 64'd0);
    end else begin
      done = 1'b0;
      for (int i = 0; i < TMO + 2 && !done; i++) begin
        chk("ld_wait_ready", 64'(m_rdy), 64'd0);
        hready = (i == waits);
        hresp  = (i == waits) ? err : 1'($urandom);
        flush  = (i == fl);
        dm     = (i == waits) ? d : {$urandom(), $urandom()};
        step();
        if (i == waits || i == TMO - 1) done = 1'b1;
      end
      hready = 1'b0; hresp = 1'b0; flush = 1'b0;
      if (kind == K_WB) begin
        chk("ld_wb_valid", 64'(m_v), 64'd1);
        chk("ld_wb_data", m_d, val);
        chk("ld_wb_rd", 64'(m_rd), 64'(r));
        chk("ld_wb_wen", 64'(m_we), 64'(w));
        chk("ld_wb_nofault", 64'(m_f), 64'd0);
        chk("ld_wb_ready", 64'(m_rdy), 64'd1);
      end else if (kind == K_FAULT) begin
        chk("ld_fault", 64'(m_f), 64'd1);
        chk("ld_fault_cause", 64'(m_c), 64'(cause));
        chk("ld_fault_nowb", 64'(m_v), 64'd0);
        step();
        chk("ld_fault_once", 64'(m_f), 64'd0);
        chk("ld_fault_ready_after", 64'(m_rdy), 64'd1);
      end else begin
        chk("ld_kill_nowb", 64'(m_v), 64'd0);
        chk("ld_kill_nofault", 64'(m_f), 64'd0);
        chk("ld_kill_ready", 64'(m_rdy), 64'd1);
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, off, waits, fl, xl;
    logic [1:0] cause, sz;
    logic [63:0] val, d, e;
    logic [2:0] s;

    tbl[0] = '{3'd0, 64'h11, 64'h11};
    tbl[1] = '{3'd0, 64'h22, 64'h22};
    tbl[2] = '{3'd2, 64'h33, 64'hA5A5_0002};
    tbl[3] = '{3'd3, 64'h44, 64'h0000_3330};
    tbl[4] = '{3'd4, 64'h55, 64'hC5C5_0004};
    tbl[5] = '{3'd5, 64'h66, 64'h0000_1005};
    tbl[6] = '{3'd6, 64'h77, 64'h0};
    tbl[7] = '{3'd7, 64'h88, 64'h0};

    g64 = 1'b0; rst = 1'b1;
    valid = 0; flush = 0; isld = 0; wen = 0; uns = 0; hready = 0; hresp = 0;
    sel = 0; rd = 0; size = 0; alu = 0; src = 0; iadd = 0; csr = 0; pc4 = 0; dm = 0;
    step(); step();
    chk("rst_ready", 64'(m_rdy), 64'd1);
    chk("rst_valid", 64'(m_v), 64'd0);
    chk("rst_data", m_d, 64'd0);
    chk("rst_fault", 64'(m_f), 64'd0);
    chk("rst_cause", 64'(m_c), 64'd0);
    chk("rst_rd", 64'(m_rd), 64'd0);
    rst = 1'b0;

    // Back-to-back non-load writebacks, one per cycle.
    src = 64'hA5A5_0002; iadd = 64'h0000_3330; csr = 64'hC5C5_0004; pc4 = 64'h0000_1005;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; isld = 1'b0; sel = tbl[i].sel; alu = tbl[i].alu;
      rd = 5'(i + 1); wen = i[0];
      step();
      chk("tbl_valid", 64'(m_v), 64'd1);
      chk("tbl_data", m_d, tbl[i].exp);
      chk("tbl_rd", 64'(m_rd), 64'(i + 1));
      chk("tbl_wen", 64'(m_we), 64'(i[0]));
    end
    // Flush in RUN blocks the accept.
    valid = 1'b1; flush = 1'b1; step();
    chk("flush_run_nowb", 64'(m_v), 64'd0);
    valid = 1'b0; flush = 1'b0; step();

    run_load(2'd0, 3, 1'b0, 64'h80FF_0000, 0, 1'b0, -1, 5'd7, 1'b1, K_WB, 2'd0, 64'hFFFF_FF80);

    // Reset asserted mid-WAIT.
    valid = 1'b1; isld = 1'b1; size = 2'd2; iadd = 64'h100; hready = 1'b0;
    step();
    valid = 1'b0;
    step();
    chk("midwait_ready", 64'(m_rdy), 64'd0);
    rst = 1'b1;
    step();
    chk("rstw_ready", 64'(m_rdy), 64'd1);
    chk("rstw_valid", 64'(m_v), 64'd0);
    chk("rstw_data", m_d, 64'd0);
    chk("rstw_rd", 64'(m_rd), 64'd0);
    chk("rstw_wen", 64'(m_we), 64'd0);
    chk("rstw_fault", 64'(m_f), 64'd0);
    rst = 1'b0; hready = 1'b1; dm = 64'hDEAD_BEEF;
    step();
    chk("rstw_stale_ignored", 64'(m_v), 64'd0);
    hready = 1'b0;

    run_load(2'd1, 2, 1'b1, 64'hBEEF_1234, 3, 1'b0, -1, 5'd9, 1'b1, K_WB, 2'd0, 64'h0000_BEEF);
    run_load(2'd2, 0, 1'b0, 64'h1234_5678, 10, 1'b0, -1, 5'd3, 1'b1, K_FAULT, 2'd1, 64'd0);
    run_load(2'd2, 0, 1'b0, 64'h1234_5678, 1, 1'b1, -1, 5'd3, 1'b1, K_FAULT, 2'd0, 64'd0);
    run_load(2'd2, 2, 1'b0, 64'h1234_5678, 0, 1'b0, -1, 5'd3, 1'b1, K_FAULT, 2'd2, 64'd0);
    run_load(2'd3, 0, 1'b0, 64'h1234_5678, 0, 1'b0, -1, 5'd3, 1'b1, K_FAULT, 2'd3, 64'd0);
    run_load(2'd2, 0, 1'b0, 64'h1234_5678, 2, 1'b0, 1, 5'd3, 1'b1, K_NONE, 2'd0, 64'd0);

    g64 = 1'b1;
    run_load(2'd3, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 1, 1'b0, -1, 5'd31, 1'b1, K_WB, 2'd0,
             64'h0123_4567_89AB_CDEF);
    run_load(2'd3, 4, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 1'b0, -1, 5'd31, 1'b1, K_FAULT, 2'd2, 64'd0);
    run_load(2'd2, 4, 1'b0, 64'h8000_0000_0000_0000, 0, 1'b0, -1, 5'd2, 1'b0, K_WB, 2'd0,
             64'hFFFF_FFFF_8000_0000);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 70; n++) begin
      g64 = (n >= 45);
      xl  = g64 ? 64 : 32;
      if ($urandom_range(0, 2) == 0) begin
        s = 3'($urandom_range(0, 6));
        if (s >= 3'd1) s = s + 3'd1;
        alu = {$urandom(), $urandom()}; src = {$urandom(), $urandom()};
        iadd = {$urandom(), $urandom()}; csr = {$urandom(), $urandom()};
        pc4 = {$urandom(), $urandom()};
        e = ref_mux(s, alu, src, iadd, csr, pc4);
        if (xl == 32) e = e & 64'hFFFF_FFFF;
        run_op(s, 5'($urandom), 1'($urandom), e);
      end else begin
        sz    = 2'($urandom_range(0, 3));
        off   = $urandom_range(0, g64 ? 7 : 3);
        waits = $urandom_range(0, 5);
        fl    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
        d     = {$urandom(), $urandom()};
        uns   = 1'($urandom);
        predict(xl, sz, off, uns, d, waits, ($urandom_range(0, 3) == 0), fl, kind, cause, val);
        run_load(sz, off, uns, d, waits, (kind == K_FAULT && cause == 2'd0), fl,
                 5'($urandom), 1'($urandom), kind, cause, val);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
